// File: rtl/uart_pkg.sv
// uart_pkg: parity modes, TX FSM encoding and default baud divisor shared by the UART blocks
package uart_pkg;
   localparam int PAR_NONE         = 0;
   localparam int PAR_EVEN         = 1;
   localparam int PAR_ODD          = 2;
   localparam int CLKS_PER_BIT_DEF = 5208;
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } tx_state_e;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period divider; bit_tick marks the last clk of each bit, clear holds the phase at zero
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_tick
);
   localparam int W = $clog2(CLKS_PER_BIT);
   logic [W-1:0] r_cnt;
   assign bit_tick = (r_cnt == W'(CLKS_PER_BIT - 1));
   always_ff @(posedge clk or posedge rst)
      if (rst) r_cnt <= '0;
      else     r_cnt <= (clear || bit_tick) ? '0 : r_cnt + W'(1);
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: double-buffered UART transmitter with configurable width, parity and stop bits
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = PAR_NONE,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [DATA_BITS-1:0] in_data,
   output logic                 in_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);
   localparam int BW = $clog2(DATA_BITS + 1);
   tx_state_e            r_state, w_next;
   logic [DATA_BITS-1:0] r_hold, r_shift;
   logic                 r_hold_full, r_par;
   logic [BW-1:0]        r_bit_cnt;
   logic                 w_tick, w_clear, w_load;
   // baud phase stays at zero while idle so every frame starts on a fresh bit period
   assign w_clear = (r_state == S_IDLE);
   uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk      (clk),
      .rst      (rst),
      .clear    (w_clear),
      .bit_tick (w_tick)
   );
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:   if (r_hold_full) w_next = S_START;
         S_START:  if (w_tick) w_next = S_DATA;
         S_DATA:   if (w_tick && r_bit_cnt == BW'(DATA_BITS - 1))
                      w_next = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
         S_PARITY: if (w_tick) w_next = S_STOP;
         S_STOP:   if (w_tick && r_bit_cnt == BW'(STOP_BITS - 1))
                      w_next = r_hold_full ? S_START : S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   assign w_load = (w_next == S_START) && (r_state != S_START);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_shift     <= '0;
         r_par       <= 1'b0;
         r_bit_cnt   <= '0;
      end else begin
         r_bit_cnt <= (w_next != r_state) ? '0 :
                      (w_tick && (r_state == S_DATA || r_state == S_STOP)) ? r_bit_cnt + BW'(1) : r_bit_cnt;
         if (w_load) begin
            r_shift     <= r_hold;
            r_par       <= (^r_hold) ^ (PARITY == PAR_ODD);
            r_hold_full <= 1'b0;
         end else begin
            if (r_state == S_DATA && w_tick) r_shift <= r_shift >> 1;
            if (in_valid && !r_hold_full) begin
               r_hold      <= in_data;
               r_hold_full <= 1'b1;
            end
         end
      end
   assign in_ready = !r_hold_full;
   assign busy     = (r_state != S_IDLE);
   assign done     = (r_state == S_STOP) && w_tick && (r_bit_cnt == BW'(STOP_BITS - 1));
   assign tx       = (r_state == S_IDLE || r_state == S_STOP) ? 1'b1 :
                     (r_state == S_START) ? 1'b0 :
                     (r_state == S_DATA)  ? r_shift[0] : r_par;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: five configurations side by side on one clock; frame table plus
// back-to-back, mid-frame reset and full-rate smoke sequences
module tb_uart_tx_frame;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] v   = '0;
   logic [4:0] txs, bsy, dn, rdy;
   logic [8:0] d [5];
   int         n_vec = 0;
   int         n_bad = 0;
   always #10 clk = ~clk;
   uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .rst(rst), .in_valid(v[0]), .in_data(d[0][7:0]),
      .in_ready(rdy[0]), .tx(txs[0]), .busy(bsy[0]), .done(dn[0]));
   uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
      .clk(clk), .rst(rst), .in_valid(v[1]), .in_data(d[1][7:0]),
      .in_ready(rdy[1]), .tx(txs[1]), .busy(bsy[1]), .done(dn[1]));
   uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
      .clk(clk), .rst(rst), .in_valid(v[2]), .in_data(d[2][7:0]),
      .in_ready(rdy[2]), .tx(txs[2]), .busy(bsy[2]), .done(dn[2]));
   uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7e2 (
      .clk(clk), .rst(rst), .in_valid(v[3]), .in_data(d[3][6:0]),
      .in_ready(rdy[3]), .tx(txs[3]), .busy(bsy[3]), .done(dn[3]));
   uart_tx_frame #(.CLKS_PER_BIT(5208), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_slow (
      .clk(clk), .rst(rst), .in_valid(v[4]), .in_data(d[4][7:0]),
      .in_ready(rdy[4]), .tx(txs[4]), .busy(bsy[4]), .done(dn[4]));
   typedef struct {
      int         k;
      logic [8:0] data;
      int         nbits;
      logic [11:0] line;
   } vec_t;
   vec_t vt [10];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // line is gathered oldest bit first into the MSB end, so literals read in wire order
   task automatic run_frame(input int k, input logic [8:0] data, input int nbits,
                            output logic [11:0] obs, output int done_at, output int idle_at);
      obs = '0;
      done_at = -1;
      idle_at = -1;
      @(negedge clk);
      d[k] = data;
      v[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v[k] = 1'b0;
      for (int c = 1; c <= nbits * 4 + 4; c++) begin
         @(posedge clk);
         @(negedge clk);
         if ((c - 1) % 4 == 2 && c <= nbits * 4) obs = {obs[10:0], txs[k]};
         if (dn[k] && done_at < 0) done_at = c;
         if (!bsy[k] && idle_at < 0) idle_at = c;
      end
   endtask
   initial begin
      logic [11:0] obs, l1, l2;
      int          done_at, idle_at, d1, d2, n_done, idle;
      time         t0, t1;
      int          dc;
      for (int i = 0; i < 5; i++) d[i] = '0;
      vt[0] = '{0, 9'h0AB, 10, 12'b0110101011};
      vt[1] = '{0, 9'h000, 10, 12'b0000000001};
      vt[2] = '{0, 9'h0FF, 10, 12'b0111111111};
      vt[3] = '{1, 9'h0AB, 11, 12'b01101010111};
      vt[4] = '{1, 9'h000, 11, 12'b00000000001};
      vt[5] = '{2, 9'h0AB, 11, 12'b01101010101};
      vt[6] = '{2, 9'h000, 11, 12'b00000000011};
      vt[7] = '{3, 9'h041, 11, 12'b01000001011};
      vt[8] = '{3, 9'h07F, 11, 12'b01111111111};
      vt[9] = '{3, 9'h001, 11, 12'b01000000111};
      repeat (3) @(negedge clk);
      chk("reset_tx", 64'(txs), 64'h1f);
      chk("reset_busy", 64'(bsy), 64'h0);
      chk("reset_done", 64'(dn), 64'h0);
      chk("reset_ready", 64'(rdy), 64'h1f);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         run_frame(vt[i].k, vt[i].data, vt[i].nbits, obs, done_at, idle_at);
         chk($sformatf("vec%0d_line", i), 64'(obs), 64'(vt[i].line));
         chk($sformatf("vec%0d_done_cycle", i), 64'(done_at), 64'(vt[i].nbits * 4));
         chk($sformatf("vec%0d_idle_cycle", i), 64'(idle_at), 64'(vt[i].nbits * 4 + 1));
      end
      // back-to-back: second word offered while the first is still in the holding register
      @(negedge clk);
      d[0] = 9'h055;
      v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      d[0] = 9'h00F;
      l1 = '0; l2 = '0; n_done = 0; d1 = -1; d2 = -1; idle = 0;
      for (int c = 1; c <= 90; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c == 1) chk("b2b_ready_rise", 64'(rdy[0]), 64'h1);
         if (c == 2) begin
            chk("b2b_second_taken", 64'(rdy[0]), 64'h0);
            v[0] = 1'b0;
         end
         if ((c - 1) % 4 == 2) begin
            if (c <= 40) l1 = {l1[10:0], txs[0]};
            else if (c <= 80) l2 = {l2[10:0], txs[0]};
         end
         if (dn[0]) begin
            n_done++;
            if (d1 < 0) d1 = c;
            else if (d2 < 0) d2 = c;
         end
         if (c <= 80 && !bsy[0]) idle++;
      end
      chk("b2b_line1", 64'(l1), 64'b0101010101);
      chk("b2b_line2", 64'(l2), 64'b0111100001);
      chk("b2b_done1", 64'(d1), 64'd40);
      chk("b2b_done2", 64'(d2), 64'd80);
      chk("b2b_done_count", 64'(n_done), 64'd2);
      chk("b2b_no_gap", 64'(idle), 64'd0);
      chk("b2b_idle_after", 64'(bsy[0]), 64'h0);
      // asynchronous reset during data bit 3 of 0xAB
      @(negedge clk);
      d[0] = 9'h0AB;
      v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v[0] = 1'b0;
      repeat (18) @(negedge clk);
      chk("midrst_busy_before", 64'(bsy[0]), 64'h1);
      #5 rst = 1'b1;
      #1;
      chk("midrst_tx", 64'(txs[0]), 64'h1);
      chk("midrst_busy", 64'(bsy[0]), 64'h0);
      chk("midrst_ready", 64'(rdy[0]), 64'h1);
      @(negedge clk);
      rst = 1'b0;
      run_frame(0, 9'h012, 10, obs, done_at, idle_at);
      chk("postrst_line", 64'(obs), 64'b0010010001);
      chk("postrst_done_cycle", 64'(done_at), 64'd40);
      // full-rate divisor: one frame, no follow-on word
      @(negedge clk);
      d[4] = 9'h0AB;
      v[4] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v[4] = 1'b0;
      t0 = 0; t1 = 0; dc = -1;
      for (int c = 1; c <= 60000; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (!txs[4] && t0 == 0) t0 = $time;
         if (txs[4] && t0 != 0 && t1 == 0) t1 = $time;
         if (dn[4]) begin
            dc = c;
            break;
         end
      end
      chk("smoke_bit_period_ns", 64'(t1 - t0), 64'd104160);
      chk("smoke_done_cycle", 64'(dc), 64'd52080);
      repeat (10) @(negedge clk);
      chk("smoke_stays_idle", 64'({bsy[4], txs[4], rdy[4]}), 64'b011);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
